multicycle_controller: RTL

Multi-cycle sequencer for the RV64 subset datapath: R-type, I-type ALU (`addi`-class), `ld`, `sd`, `beq`. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It drives the strobes that gate the register file, immediate path, ALU and a single shared instruction/data memory port. It also enforces a memory-ready handshake with a timeout, and counts retired instructions.

---
 rtl/multicycle_controller.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
`timescale 1ns/1ps
// multicycle_controller
// Multi-cycle sequencer for an RV64 subset (R-type, I-type ALU, ld, sd, beq).
// It steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and
// drives the datapath strobes. It also guards every memory access with a
// ready timeout and counts retired instructions.
//
// Optional feature macro: MC_ILLEGAL_TRAP_EN
//   defined   : unknown opcodes trap (TRAP state, sticky illegal_inst port)
//   undefined : unknown opcodes retire as NOPs; no illegal_inst port
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode[6:0]         inst[6:0] from the IR, latched at the end of DECODE
//   zero                ALU zero flag (used in EXECUTE for beq)
//   mem_ready           memory completes the current access this cycle
//   mem_read/mem_write  memory requests; i_or_d selects PC (0) / ALU (1)
//   ir_write, pc_write, pc_src, alu_src, alu_op[1:0], reg_write, mem_to_reg
//                       datapath strobes (combinational)
//   state[2:0]          current state (debug)
//   instr_retired       one-cycle retire strobe (combinational)
//   instret[31:0]       retired-instruction counter
//   mem_timeout         sticky memory-timeout fault
//   illegal_inst        sticky illegal-opcode flag (MC_ILLEGAL_TRAP_EN only)
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [2:0]  state,
  output logic        instr_retired,
  output logic [31:0] instret,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic        illegal_inst,
`endif
  output logic        mem_timeout
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned OPC_W  = 7;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_ITYPE = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LD    = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_SD    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Last wait-counter value of an access: the MEM_TIMEOUT-th cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_TRAP      = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [OPC_W-1:0]   opcode_q, opcode_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic               wait_expired;
`ifdef MC_ILLEGAL_TRAP_EN
  logic               illegal_q, illegal_d;
`endif

  assign wait_expired = (wait_q == WAIT_LAST);

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      opcode_q      <= '0;
      wait_q        <= '0;
      instret_q     <= '0;
      mem_timeout_q <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      wait_q        <= wait_d;
      instret_q     <= instret_d;
      mem_timeout_q <= mem_timeout_d;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q     <= illegal_d;
`endif
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    mem_timeout_d = mem_timeout_q;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_d     = illegal_q;
`endif
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    alu_src       = 1'b0;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    instr_retired = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          state_d       = S_HALT;
          mem_timeout_d = 1'b1;
        end
      end

      S_DECODE: begin
        opcode_d = opcode;
        case (opcode)
          OPC_RTYPE, OPC_ITYPE, OPC_LD, OPC_SD, OPC_BEQ: state_d = S_EXECUTE;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_d   = S_TRAP;
            illegal_d = 1'b1;
`else
            // Unknown opcode retires as a NOP; PC already advanced in FETCH.
            instr_retired = 1'b1;
            state_d       = S_FETCH;
`endif
          end
        endcase
      end

      S_EXECUTE: begin
        case (opcode_q)
          OPC_RTYPE: begin
            alu_op  = ALU_FUNCT;
            state_d = S_WRITEBACK;
          end
          OPC_ITYPE: begin
            alu_src = 1'b1;
            alu_op  = ALU_FUNCT;
            state_d = S_WRITEBACK;
          end
          OPC_LD, OPC_SD: begin
            alu_src = 1'b1;
            state_d = S_MEMORY;
          end
          OPC_BEQ: begin
            alu_op        = ALU_SUB;
            pc_write      = zero;
            pc_src        = zero;
            instr_retired = 1'b1;
            state_d       = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEMORY: begin
        // Address and ALU controls held so the effective address stays stable.
        i_or_d    = 1'b1;
        alu_src   = 1'b1;
        mem_read  = (opcode_q == OPC_LD);
        mem_write = (opcode_q == OPC_SD);
        if (mem_ready) begin
          if (opcode_q == OPC_LD) begin
            state_d = S_WRITEBACK;
          end else begin
            instr_retired = (opcode_q == OPC_SD);
            state_d       = S_FETCH;
          end
        end else if (wait_expired) begin
          state_d       = S_HALT;
          mem_timeout_d = 1'b1;
        end
      end

      S_WRITEBACK: begin
        reg_write     = 1'b1;
        mem_to_reg    = (opcode_q == OPC_LD);
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_FETCH;
    endcase

    // Reset kills every strobe immediately, ahead of the flops.
    if (!rst_n) begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 1'b0;
      alu_src       = 1'b0;
      alu_op        = ALU_ADD;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      instr_retired = 1'b0;
    end
  end

  // Wait counter: restarts on every entry to a memory state, counts stall cycles.
  always_comb begin
    wait_d = '0;
    if ((state_q == S_FETCH || state_q == S_MEMORY) && (state_d == state_q)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  assign instret_d = instret_q + CNT_W'(instr_retired);

  assign state       = state_q;
  assign instret     = instret_q;
  assign mem_timeout = mem_timeout_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_inst = illegal_q;
`endif

endmodule
